// File: rtl/stopwatch_ctrl_if.sv
// Button-side and display-side signals of the stopwatch controller.
// master = button/display logic, slave = stopwatch_ctrl.
interface stopwatch_ctrl_if;
  logic        start_stop;
  logic        lap;
  logic        clear;
  logic [15:0] disp;
  logic        running;
  logic        lap_active;
  logic        rollover;

  modport master (
    output start_stop, lap, clear,
    input  disp, running, lap_active, rollover
  );

  modport slave (
    input  start_stop, lap, clear,
    output disp, running, lap_active, rollover
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear stopwatch: tick prescaler, control FSM, 4-digit BCD chain, lap snapshot.
// Optional macro STOPWATCH_EDGE_DETECT_EN: turns level button inputs into rising-edge events.
//
// state   | meaning
// IDLE    | stopped at zero, waiting for start
// RUN     | counting, display shows live count
// LAP     | counting, display frozen on snapshot
// PAUSE   | stopped, count and prescaler phase held
module stopwatch_ctrl #(
  parameter int unsigned DIV = 5000000
) (
  input  logic           clk,
  input  logic           reset,
  stopwatch_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [15:0]   cnt, cnt_nxt;
  logic [15:0]   snap, snap_nxt;
  logic          roll_nxt;
  logic          counting;
  logic          tick;
  logic [4:0]    carry;
  logic          ev_ss, ev_lap, ev_clear;

`ifdef STOPWATCH_EDGE_DETECT_EN
  logic [2:0] btn_cur, btn_prev;

  // Edge registers clear to 0 so a button already held at reset release yields one event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_cur  <= '0;
      btn_prev <= '0;
    end else begin
      btn_cur  <= {bus.clear, bus.start_stop, bus.lap};
      btn_prev <= btn_cur;
    end
  end

  assign {ev_clear, ev_ss, ev_lap} = btn_cur & ~btn_prev;
`else
  assign ev_clear = bus.clear;
  assign ev_ss    = bus.start_stop;
  assign ev_lap   = bus.lap;
`endif

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    counting  = (state == S_RUN) || (state == S_LAP);
    tick      = counting && (presc == PRE_MAX);
    carry     = '0;
    carry[0]  = tick;

    if (counting) presc_nxt = tick ? '0 : presc + 1'b1;

    for (int i = 0; i < 4; i++) begin
      carry[i+1] = carry[i] && (cnt[i*4 +: 4] == 4'd9);
      if (carry[i])
        cnt_nxt[i*4 +: 4] = (cnt[i*4 +: 4] == 4'd9) ? 4'd0 : cnt[i*4 +: 4] + 4'd1;
    end
    roll_nxt = carry[4];

    // Highest-priority legal event wins; clear outranks start_stop outranks lap.
    case (state)
      S_IDLE: begin
        if (!ev_clear && ev_ss) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (ev_ss) begin
          state_nxt = S_PAUSE;
        end else if (ev_lap) begin
          state_nxt = S_LAP;
          snap_nxt  = cnt;
        end
      end
      S_LAP: begin
        if (ev_ss)       state_nxt = S_PAUSE;
        else if (ev_lap) state_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (ev_clear) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          snap_nxt  = '0;
          presc_nxt = '0;
        end else if (ev_ss) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      presc          <= '0;
      cnt            <= '0;
      snap           <= '0;
      bus.disp       <= '0;
      bus.running    <= 1'b0;
      bus.lap_active <= 1'b0;
      bus.rollover   <= 1'b0;
    end else begin
      state          <= state_nxt;
      presc          <= presc_nxt;
      cnt            <= cnt_nxt;
      snap           <= snap_nxt;
      bus.disp       <= (state_nxt == S_LAP) ? snap_nxt : cnt_nxt;
      bus.running    <= (state_nxt == S_RUN) || (state_nxt == S_LAP);
      bus.lap_active <= (state_nxt == S_LAP);
      bus.rollover   <= roll_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=4; expected values are hand-computed edge counts.
// Timing is relative to the edge on which an event acts, so the same sequence serves both builds.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sw)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    sw.start_stop = 1'b0;
    sw.lap        = 1'b0;
    sw.clear      = 1'b0;
    reset         = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge just after the edge on which the event acts.
  task automatic pulse(input logic ss, input logic lp, input logic cl);
    sw.start_stop = ss;
    sw.lap        = lp;
    sw.clear      = cl;
    step(1);
    sw.start_stop = 1'b0;
    sw.lap        = 1'b0;
    sw.clear      = 1'b0;
`ifdef STOPWATCH_EDGE_DETECT_EN
    step(1);
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sw.start_stop = 1'b0;
    sw.lap        = 1'b0;
    sw.clear      = 1'b0;
    step(1);
    chk_val("rst_disp",    32'(sw.disp), 32'h0000);
    chk_val("rst_running", 32'(sw.running), 32'd0);
    chk_val("rst_lap",     32'(sw.lap_active), 32'd0);
    chk_val("rst_roll",    32'(sw.rollover), 32'd0);

    // start, first tick after DIV cycles, 10 counts after 40 cycles
    do_reset();
    pulse(1, 0, 0);
    chk_val("start_running", 32'(sw.running), 32'd1);
    step(3);
    chk_val("pre_first_tick", 32'(sw.disp), 32'h0000);
    step(1);
    chk_val("first_tick", 32'(sw.disp), 32'h0001);
    step(36);
    chk_val("forty_cycles", 32'(sw.disp), 32'h0010);

    // lap freeze and release
    do_reset();
    pulse(1, 0, 0);
    step(12);
    chk_val("lap_pre", 32'(sw.disp), 32'h0003);
    pulse(0, 1, 0);
    chk_val("lap_active", 32'(sw.lap_active), 32'd1);
    chk_val("lap_running", 32'(sw.running), 32'd1);
    for (int i = 0; i < 19; i++) begin
      chk_val("lap_frozen", 32'(sw.disp), 32'h0003);
      step(1);
    end
    chk_val("lap_frozen_end", 32'(sw.disp), 32'h0003);
    pulse(0, 1, 0);
    chk_val("lap_release_disp", 32'(sw.disp), 32'h0008);
    chk_val("lap_release_flag", 32'(sw.lap_active), 32'd0);

    // rollover 9999 -> 0000
    do_reset();
    pulse(1, 0, 0);
    step(39992);
    chk_val("preload_9998", 32'(sw.disp), 32'h9998);
    step(4);
    chk_val("at_9999", 32'(sw.disp), 32'h9999);
    chk_val("roll_low_before", 32'(sw.rollover), 32'd0);
    step(3);
    chk_val("hold_9999", 32'(sw.disp), 32'h9999);
    step(1);
    chk_val("wrap_0000", 32'(sw.disp), 32'h0000);
    chk_val("roll_pulse", 32'(sw.rollover), 32'd1);
    step(1);
    chk_val("roll_low_after", 32'(sw.rollover), 32'd0);

    // pause keeps prescaler phase, then clear to IDLE
    do_reset();
    pulse(1, 0, 0);
    step(9);
    pulse(1, 0, 0);
    chk_val("pause_running", 32'(sw.running), 32'd0);
    chk_val("pause_disp", 32'(sw.disp), 32'h0002);
    for (int i = 0; i < 5; i++) begin
      step(10);
      chk_val("pause_hold", 32'(sw.disp), 32'h0002);
    end
    pulse(1, 0, 0);
    chk_val("resume_running", 32'(sw.running), 32'd1);
    step(1);
    chk_val("resume_plus1", 32'(sw.disp), 32'h0002);
    step(1);
    chk_val("resume_plus2", 32'(sw.disp), 32'h0003);
    pulse(1, 0, 0);
    chk_val("repause_disp", 32'(sw.disp), 32'h0003);
    pulse(0, 0, 1);
    chk_val("clear_disp", 32'(sw.disp), 32'h0000);
    chk_val("clear_running", 32'(sw.running), 32'd0);
    pulse(1, 0, 0);
    step(3);
    chk_val("after_clear_pre", 32'(sw.disp), 32'h0000);
    step(1);
    chk_val("after_clear_tick", 32'(sw.disp), 32'h0001);

    // clear ignored in RUN; start_stop beats lap; clear beats start_stop in PAUSE
    pulse(0, 0, 1);
    chk_val("run_clear_running", 32'(sw.running), 32'd1);
    chk_val("run_clear_disp", 32'(sw.disp), 32'h0001);
    step(3);
    chk_val("run_clear_counts", 32'(sw.disp), 32'h0002);
    pulse(1, 1, 0);
    chk_val("ss_lap_running", 32'(sw.running), 32'd0);
    chk_val("ss_lap_lapflag", 32'(sw.lap_active), 32'd0);
    chk_val("ss_lap_disp", 32'(sw.disp), 32'h0002);
    pulse(1, 0, 1);
    chk_val("cl_ss_disp", 32'(sw.disp), 32'h0000);
    chk_val("cl_ss_running", 32'(sw.running), 32'd0);
    pulse(1, 0, 0);
    step(3);
    chk_val("cl_ss_restart_pre", 32'(sw.disp), 32'h0000);
    step(1);
    chk_val("cl_ss_restart_tick", 32'(sw.disp), 32'h0001);

    // asynchronous reset between clock edges
    step(2);
    #2;
    reset = 1'b1;
    #1;
    chk_val("async_rst_disp", 32'(sw.disp), 32'h0000);
    chk_val("async_rst_running", 32'(sw.running), 32'd0);
    step(1);
    reset = 1'b0;
    step(6);
    chk_val("post_rst_idle", 32'(sw.running), 32'd0);
    chk_val("post_rst_disp", 32'(sw.disp), 32'h0000);

`ifdef STOPWATCH_EDGE_DETECT_EN
    // held button yields one event only
    do_reset();
    sw.start_stop = 1'b1;
    step(2);
    chk_val("hold_enter_run", 32'(sw.running), 32'd1);
    step(28);
    chk_val("hold_stay_run", 32'(sw.running), 32'd1);
    sw.start_stop = 1'b0;
    step(3);
    chk_val("hold_release_run", 32'(sw.running), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Controller that sequences a 4-digit BCD mod-10 counter chain as a start/stop/lap/clear stopwatch.
- Contains its own tick prescaler, a control FSM, four cascaded mod-10 digits and a lap snapshot register.
- Sits between board push-button logic and the seven-segment display driver.
- Replaces free-running divider-plus-counter pairs wherever user-sequenced counting is required.

Parameters:
DIV, 5000000, clk cycles per count tick (≥2); prescaler width = $clog2(DIV).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
start_stop  input  1  start/pause request (event semantics per Optional Feature)
lap  input  1  lap freeze/release request
clear  input  1  zero request (honoured only in IDLE/PAUSE)
disp  output  16  displayed count, BCD, digit3 = [15:12] … digit0 = [3:0]
running  output  1  high in RUN and LAP
lap_active  output  1  high in LAP
rollover  output  1  one-cycle pulse on 9999→0000 wrap

Behaviour:
- Reset (async, active-high): state=IDLE, prescaler=0, live count=0000, snapshot=0000, disp=0000, running=0, lap_active=0, rollover=0.
- States: IDLE, RUN, LAP, PAUSE. All outputs are registered or decoded from registered state.
- Event priority when several events occur in one cycle: clear > start_stop > lap. Only the highest-priority event that is legal in the current state acts; the others are dropped.
- Transitions (event at edge n, new state visible after edge n):
  - IDLE: start_stop→RUN; clear→IDLE (no-op); lap ignored.
  - RUN: start_stop→PAUSE; lap→LAP and snapshot←live count (same edge); clear ignored.
  - LAP: lap→RUN; start_stop→PAUSE; clear ignored. The live count keeps advancing in LAP.
  - PAUSE: start_stop→RUN; clear→IDLE, zeroing live count, snapshot and prescaler; lap ignored.
- Prescaler:
  - Increments every cycle in RUN and LAP.
  - At DIV-1 it wraps to 0 and asserts an internal tick for that cycle.
  - Holds its value in PAUSE, so resume keeps phase. Reset only by reset or by clear.
  - After start from IDLE, the first count increment lands exactly DIV cycles later.
- Digit chain:
  - On tick, digit0 += 1. Each digit wraps 9→0 and carries to the next.
  - 9999 + tick gives 0000 and rollover=1 for exactly one cycle. Counting continues; no saturation.
  - Digits never take values 10–15.
- disp = snapshot in LAP, live count otherwise.
  - Returning to RUN shows the live value on the next cycle.
  - Going LAP→PAUSE shows the live value.
- A tick and a state-changing event in the same cycle: the tick is applied, since the tick is qualified by the current (pre-edge) state.
- Reset asserted mid-count: immediate return to reset values regardless of clk; counting resumes only after a new start_stop.

Optional Feature:
Macro STOPWATCH_EDGE_DETECT_EN.
- Defined: each button input is registered once; an event is its rising edge (prev=0, cur=1). Holding a button high produces a single event, and every event is delayed one cycle. The edge registers reset to 0, so an input already high at reset release produces one event.
- Undefined: inputs are used directly as events. Every cycle high counts as an event, so the driver must supply single-cycle pulses.

Test Plan (DIV=4, macro undefined unless stated):
- Reset, then start_stop pulse at cycle 0 → running=1 at cycle 1; disp=0001 after 4 further cycles; 0010 after 40 cycles of RUN.
- RUN until disp=0003, pulse lap → disp frozen at 0003 for 20 cycles while the live count reaches 0008. Pulse lap → disp=0008 next cycle, lap_active=0.
- Preload to 9998 by running 39992 cycles, continue 8 cycles → disp 9999 then 0000, with rollover high for exactly one cycle.
- RUN, start_stop at prescaler=2 → PAUSE, disp constant for 50 cycles. start_stop → next increment 2 cycles later. Then start_stop, clear → state IDLE, disp=0000.
- clear and start_stop in the same cycle while in PAUSE → IDLE with 0000 (clear wins). clear in RUN → ignored, counting continues.
- Macro defined, start_stop held high 30 cycles → one event only: RUN entered once and stays RUN. Reset asserted mid-count, between clk edges → disp=0000 and running=0 immediately.
